// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - FSM state enumeration (IDLE / WAIT / RESP)
//   - default DEPTH and LATENCY values
//   - word-index width of a 32-bit byte address
//   - addr_err(): misaligned or out-of-range check for a request address
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_DEF   = 32;
  localparam int unsigned DMEM_LATENCY_DEF = 2;
  localparam int unsigned WORD_IDX_W       = 30;  // req_addr[31:2]
  localparam int unsigned CNT_W            = 4;   // holds LATENCY-1, LATENCY <= 15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A request is in error when it is not word aligned or its word index
  // falls beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int unsigned depth);
    logic [31:0] w_word;
    w_word = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (w_word >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// Ports:
//   i_clk    clock, writes on rising edge
//   i_rst_n  asynchronous active-low reset, clears every word to 0
//   i_we     write strobe
//   i_idx    word index for both write and read
//   i_wdata  write data
//   i_be     byte enables, bit i covers bits [8i+7:8i]
//   o_rdata  combinational read of word i_idx
module dmem_array #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed response latency.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and its
// response is held in RESP until the initiator takes it.
// Ports:
//   CLK, RST               clock; asynchronous active-low reset
//   req_valid / req_ready  request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata, req_be  request payload
//   rsp_valid / rsp_ready  response handshake
//   rsp_rdata, rsp_err     read data (0 for writes/errors), error flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DMEM_DEPTH_DEF,
  parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LOAD_CNT =
    (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;

  logic        r_req_write;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_be;

  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_cur_write;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [3:0]  w_cur_be;
  logic        w_cur_err;
  logic        w_mem_we;
  logic [31:0] w_mem_rdata;

  assign req_ready = (r_state == IDLE) && RST;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // RESP is entered from IDLE only when LATENCY is 0, i.e. on the accepting
  // edge itself, before the request registers hold the payload. Using the
  // live inputs in IDLE covers that case; otherwise the captured copy is used.
  assign w_cur_write = (r_state == IDLE) ? req_write : r_req_write;
  assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_req_addr;
  assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_req_wdata;
  assign w_cur_be    = (r_state == IDLE) ? req_be    : r_req_be;
  assign w_cur_err   = addr_err(w_cur_addr, DEPTH);
  assign w_mem_we    = w_enter_resp && w_cur_write && !w_cur_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_we    (w_mem_we),
    .i_idx   (w_cur_addr[AW+1:2]),
    .i_wdata (w_cur_wdata),
    .i_be    (w_cur_be),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_next_state = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = LOAD_CNT;
          end
        end
      end
      WAIT: begin
        if (r_cnt != '0) begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end else begin
          w_next_state = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Payload copy; only meaningful between acceptance and response.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_req_write <= req_write;
      r_req_addr  <= req_addr;
      r_req_wdata <= req_wdata;
      r_req_be    <= req_be;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_enter_resp) begin
      r_rsp_err   <= w_cur_err;
      r_rsp_rdata <= (w_cur_write || w_cur_err) ? '0 : w_mem_rdata;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int errors;

  dmem_responder #(
    .DEPTH   (32),
    .LATENCY (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Issues one request with rsp_ready held at 1 and returns the number of
  // cycles from acceptance to rsp_valid plus the sampled response.
  // After acceptance the payload inputs are scrambled.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output int lat, output logic [31:0] rdata,
                       output logic err, output bit to);
    int n;
    to = 1'b0; lat = 0; rdata = '0; err = 1'b0;
    rsp_ready = 1'b1;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    if (!req_ready) begin
      to = 1'b1; req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    req_write = ~wr; req_addr = 32'h0000_000C;
    req_wdata = 32'hA5A5_5A5A; req_be = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    if (!rsp_valid) begin
      to = 1'b1;
      return;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    #12;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 00000000", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    #11;
    RST = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er; bit to;
    issue(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, lat, rd, er, to);
    checks++; if (to) begin errors++; $display("FAIL wr08_timeout: got timeout expected response"); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr08_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr08_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr08_rdata: got %h expected 00000000", rd); end
    issue(1'b0, 32'h08, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (to) begin errors++; $display("FAIL rd08_timeout: got timeout expected response"); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd08_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd08_rdata: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd08_err: got %b expected 0", er); end
  endtask

  task automatic test_byte_enable();
    int lat; logic [31:0] rd; logic er; bit to;
    issue(1'b1, 32'h08, 32'h00001234, 4'h3, lat, rd, er, to);
    checks++; if (er !== 1'b0 || to) begin errors++; $display("FAIL be3_write: got err %b timeout %0d expected 0 0", er, to); end
    issue(1'b0, 32'h08, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL be3_read: got %h expected dead1234", rd); end
    issue(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, lat, rd, er, to);
    checks++; if (to) begin errors++; $display("FAIL be0_timeout: got timeout expected response"); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0_err: got %b expected 0", er); end
    issue(1'b0, 32'h08, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL be0_read: got %h expected dead1234", rd); end
    issue(1'b1, 32'h7C, 32'h8000_0001, 4'hC, lat, rd, er, to);
    issue(1'b0, 32'h7C, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'h8000_0000 || er !== 1'b0) begin errors++; $display("FAIL last_word: got %h err %b expected 80000000 err 0", rd, er); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; bit to;
    issue(1'b0, 32'h0A, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 00000000", rd); end
    issue(1'b0, 32'h80, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_rdata: got %h expected 00000000", rd); end
    issue(1'b1, 32'h80, 32'h1111_1111, 4'hF, lat, rd, er, to);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_wr_err: got %b expected 1", er); end
    issue(1'b1, 32'h0A, 32'h2222_2222, 4'hF, lat, rd, er, to);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_wr_err: got %b expected 1", er); end
    issue(1'b0, 32'h00, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_wr_suppressed: got %h expected 00000000", rd); end
    issue(1'b0, 32'h08, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL err_storage_kept: got %h expected dead1234", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h08; req_wdata = '0; req_be = '0;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge CLK); #1; n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_arrive: got %b expected 1", rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d: got %b expected 1", c, rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEAD1234) begin errors++; $display("FAIL bp_hold_rdata cyc %0d: got %h expected dead1234", c, rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold_err cyc %0d: got %b expected 0", c, rsp_err); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready cyc %0d: got %b expected 0", c, req_ready); end
      @(posedge CLK); #1;
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_idle: got %b expected 1", req_ready); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_release_rdata: got %h expected 00000000", rsp_rdata); end
  endtask

  task automatic test_reset_abort();
    int n; int lat; logic [31:0] rd; logic er; bit to;
    rsp_ready = 1'b1;
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h55; req_be = 4'hF;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    RST = 1'b0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_req_ready: got %b expected 0", req_ready); end
    @(posedge CLK); #3;
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", req_ready); end
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid !== 1'b0) n++;
      @(posedge CLK); #1;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_no_rsp: got %0d response cycles expected 0", n); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'h0 || to) begin errors++; $display("FAIL abort_not_committed: got %h timeout %0d expected 00000000 0", rd, to); end
    issue(1'b0, 32'h08, 32'h0, 4'h0, lat, rd, er, to);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_clears_storage: got %h expected 00000000", rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
